// File: rtl/vscale_hasti_wbuf_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vscale_hasti_wbuf_bridge_pkg
// Description : Shared HASTI (AHB-Lite) encodings, bridge FSM state encoding
//               and the request legality helper for the write-buffer bridge.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package vscale_hasti_wbuf_bridge_pkg;

    localparam logic [1:0] HASTI_TRANS_IDLE     = 2'b00;
    localparam logic [1:0] HASTI_TRANS_NONSEQ   = 2'b10;
    localparam logic [2:0] HASTI_BURST_SINGLE   = 3'b000;
    localparam logic       HASTI_MASTER_NO_LOCK = 1'b0;
    localparam logic       HASTI_RESP_OKAY      = 1'b0;
    localparam logic       HASTI_RESP_ERROR     = 1'b1;
    localparam logic [3:0] HASTI_PROT_DATA_PRIV = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } bridge_state_t;

    // A request is legal when its size fits the data bus and the byte
    // address is naturally aligned to that size.
    function automatic logic req_legal(input logic [2:0] size,
                                       input logic [2:0] addr_lo,
                                       input logic [2:0] max_size);
        logic [7:0] mask;
        mask      = (8'd1 << size) - 8'd1;
        req_legal = (size <= max_size) && ((addr_lo & mask[2:0]) == 3'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vscale_hasti_wbuf_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : vscale_hasti_wbuf_bridge_if
// Description : Bundle of the core request/response channel, the write-error
//               reporting signals and the HASTI master bus.
//               master : bridge view (drives the bus and the core responses)
//               slave  : environment view (core + interconnect)
// Revision    : 1.0 - initial release
// ============================================================================
interface vscale_hasti_wbuf_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // HASTI bus
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic              hmastlock;
    logic [3:0]        hprot;
    logic [1:0]        htrans;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;
    // Core request / response
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    // Write buffer status and posted-write error capture
    logic              wbuf_empty;
    logic              werr_valid;
    logic [ADDR_W-1:0] werr_addr;
    logic              werr_clr;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp,
        input  req_valid, req_wen, req_size, req_addr, req_wdata, werr_clr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output wbuf_empty, werr_valid, werr_addr
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp,
        output req_valid, req_wen, req_size, req_addr, req_wdata, werr_clr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  wbuf_empty, werr_valid, werr_addr
    );
endinterface
`default_nettype wire

// File: rtl/vscale_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vscale_sync_fifo
// Description : Single-clock FIFO with registered storage. Push and pop in the
//               same cycle are both honoured. Head entry is visible on head_o
//               while not empty (show-ahead).
// Ports       : clk, rst_n (async active-low), push_i/push_data_i,
//               pop_i, full_o, empty_o, head_o
// Revision    : 1.0 - initial release
// ============================================================================
module vscale_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [WIDTH-1:0]      head_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/vscale_hasti_wbuf_bridge.sv
`default_nettype none
// ============================================================================
// Module      : vscale_hasti_wbuf_bridge
// Description : Core-to-HASTI master bridge with a posted-write buffer.
//               Writes are queued and retired in order; reads wait until the
//               buffer drains, preserving program order. Each transfer runs
//               IDLE -> ADDR -> DATA with registered address-phase outputs.
// Ports       : hclk, hresetn (async active-low),
//               bus : master modport carrying the HASTI bus, the core
//                     request/response channel and write-error reporting
// Revision    : 1.0 - initial release
// ============================================================================
module vscale_hasti_wbuf_bridge
    import vscale_hasti_wbuf_bridge_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  wire logic                 hclk,
    input  wire logic                 hresetn,
    vscale_hasti_wbuf_bridge_if.master bus
);
    localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;
    localparam int         ENT_W    = ADDR_W + 3 + DATA_W;

    bridge_state_t     state_q,      state_d;
    logic [ADDR_W-1:0] haddr_q,      haddr_d;
    logic              hwrite_q,     hwrite_d;
    logic [2:0]        hsize_q,      hsize_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] hwdata_q,     hwdata_d;
    logic              ill_rsp_q,    ill_rsp_d;
    logic              werr_valid_q, werr_valid_d;
    logic [ADDR_W-1:0] werr_addr_q,  werr_addr_d;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ENT_W-1:0]  w_head;
    logic [ADDR_W-1:0] w_head_addr;
    logic [2:0]        w_head_size;
    logic [DATA_W-1:0] w_head_data;
    logic              w_legal;
    logic              w_req_ready;
    logic              w_acc;
    logic              w_push;
    logic              w_rd_acc;
    logic              w_ill_rd;
    logic              w_ill_wr;
    logic              w_done;
    logic              w_rd_done;
    logic              w_pop;
    logic              w_bus_werr;
    logic              w_new_err;

    assign w_legal     = req_legal(bus.req_size, bus.req_addr[2:0], MAX_SIZE);
    // Reads only enter an idle, drained bridge: strict program order.
    assign w_req_ready = bus.req_wen ? !w_fifo_full
                                     : (w_fifo_empty && (state_q == ST_IDLE) && !ill_rsp_q);
    assign w_acc       = bus.req_valid && w_req_ready;
    assign w_push      = w_acc && bus.req_wen && w_legal;
    assign w_rd_acc    = w_acc && !bus.req_wen && w_legal;
    assign w_ill_rd    = w_acc && !bus.req_wen && !w_legal;
    assign w_ill_wr    = w_acc && bus.req_wen && !w_legal;

    // Completion only on the final (hready=1) cycle, covering two-cycle ERROR.
    assign w_done      = (state_q == ST_DATA) && bus.hready;
    assign w_rd_done   = w_done && !hwrite_q;
    // The head entry stays queued until its data phase retires.
    assign w_pop       = w_done && hwrite_q;
    assign w_bus_werr  = w_pop && (bus.hresp == HASTI_RESP_ERROR);
    assign w_new_err   = w_bus_werr || w_ill_wr;

    assign w_head_addr = w_head[ENT_W-1 -: ADDR_W];
    assign w_head_size = w_head[DATA_W+2 : DATA_W];
    assign w_head_data = w_head[DATA_W-1:0];

    vscale_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (hclk),
        .rst_n       (hresetn),
        .push_i      (w_push),
        .push_data_i ({bus.req_addr, bus.req_size, bus.req_wdata}),
        .pop_i       (w_pop),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .head_o      (w_head)
    );

    // State register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_IDLE;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
            wdata_q      <= '0;
            hwdata_q     <= '0;
            ill_rsp_q    <= 1'b0;
            werr_valid_q <= 1'b0;
            werr_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            wdata_q      <= wdata_d;
            hwdata_q     <= hwdata_d;
            ill_rsp_q    <= ill_rsp_d;
            werr_valid_q <= werr_valid_d;
            werr_addr_q  <= werr_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        wdata_d  = wdata_q;
        hwdata_d = hwdata_q;
        case (state_q)
            ST_IDLE: begin
                // A read is only accepted with the buffer empty, so the two
                // sources are mutually exclusive.
                if (w_rd_acc) begin
                    haddr_d  = bus.req_addr;
                    hwrite_d = 1'b0;
                    hsize_d  = bus.req_size;
                    wdata_d  = '0;
                    state_d  = ST_ADDR;
                end else if (!w_fifo_empty) begin
                    haddr_d  = w_head_addr;
                    hwrite_d = 1'b1;
                    hsize_d  = w_head_size;
                    wdata_d  = w_head_data;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.hready) begin
                    hwdata_d = wdata_q;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.hready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ill_rsp_d = w_ill_rd;

        // First error is sticky; a clear coinciding with a new error loses.
        werr_valid_d = werr_valid_q;
        werr_addr_d  = werr_addr_q;
        if (w_new_err && (!werr_valid_q || bus.werr_clr)) begin
            werr_valid_d = 1'b1;
            werr_addr_d  = w_bus_werr ? haddr_q : bus.req_addr;
        end else if (bus.werr_clr) begin
            werr_valid_d = 1'b0;
        end
    end

    // Output logic
    always_comb begin
        bus.haddr      = haddr_q;
        bus.hwrite     = hwrite_q;
        bus.hsize      = hsize_q;
        bus.hburst     = HASTI_BURST_SINGLE;
        bus.hmastlock  = HASTI_MASTER_NO_LOCK;
        bus.hprot      = HASTI_PROT_DATA_PRIV;
        bus.htrans     = (state_q == ST_ADDR) ? HASTI_TRANS_NONSEQ : HASTI_TRANS_IDLE;
        bus.hwdata     = hwdata_q;
        bus.req_ready  = w_req_ready;
        bus.rsp_valid  = w_rd_done || ill_rsp_q;
        bus.rsp_rdata  = bus.hrdata;
        bus.rsp_err    = ill_rsp_q || (w_rd_done && (bus.hresp == HASTI_RESP_ERROR));
        bus.wbuf_empty = w_fifo_empty && !((state_q != ST_IDLE) && hwrite_q);
        bus.werr_valid = werr_valid_q;
        bus.werr_addr  = werr_addr_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_vscale_hasti_wbuf_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_vscale_hasti_wbuf_bridge
// Description : Directed self-checking bench for vscale_hasti_wbuf_bridge
//               (ADDR_W=32, DATA_W=32, WBUF_DEPTH=4). The bench acts as both
//               the core and a simple HASTI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vscale_hasti_wbuf_bridge;
    import vscale_hasti_wbuf_bridge_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [31:0] alog[$];
    bit          wlog[$];
    logic [31:0] dlog[$];
    logic        dphase;

    vscale_hasti_wbuf_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    vscale_hasti_wbuf_bridge #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .WBUF_DEPTH (4)
    ) dut (
        .hclk    (clk),
        .hresetn (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: logs completed address phases and their data phases.
    always @(negedge clk) begin
        if (!rst_n) begin
            dphase <= 1'b0;
        end else begin
            if (dphase && bus_if.hready) begin
                dlog.push_back(bus_if.hwdata);
                dphase <= 1'b0;
            end
            if (bus_if.htrans == HASTI_TRANS_NONSEQ && bus_if.hready) begin
                alog.push_back(bus_if.haddr);
                wlog.push_back(bus_if.hwrite);
                dphase <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus_if.req_ready && n < 50) begin
            step();
            #1;
            n++;
        end
        check(tag, bus_if.req_ready, 1);
    endtask

    task automatic set_req(input bit wen, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] d);
        bus_if.req_valid = 1'b1;
        bus_if.req_wen   = wen;
        bus_if.req_addr  = a;
        bus_if.req_size  = sz;
        bus_if.req_wdata = d;
    endtask

    // Posts one write and completes it on the bus, optionally with a
    // two-cycle ERROR response and a werr_clr on the final error cycle.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input bit err, input bit clr_last);
        int n = 0;
        bus_if.hready = 1'b1;
        set_req(1'b1, a, 3'd2, d);
        #1;
        wait_ready("bw_accept");
        step();
        bus_if.req_valid = 1'b0;
        #1;
        while (bus_if.htrans != HASTI_TRANS_NONSEQ && n < 20) begin
            step();
            #1;
            n++;
        end
        check("bw_nonseq_haddr", bus_if.haddr, a);
        step();
        if (err) begin
            bus_if.hready = 1'b0;
            bus_if.hresp  = HASTI_RESP_ERROR;
            step();
            bus_if.hready   = 1'b1;
            bus_if.werr_clr = clr_last;
            step();
            bus_if.hresp    = HASTI_RESP_OKAY;
            bus_if.werr_clr = 1'b0;
        end else begin
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int abase;
        int dbase;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_wen   = 1'b0;
        bus_if.req_size  = 3'd0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.werr_clr  = 1'b0;
        bus_if.hready    = 1'b1;
        bus_if.hresp     = HASTI_RESP_OKAY;
        bus_if.hrdata    = 32'hDEADBEEF;
        repeat (3) step();

        // ---------------- reset state ----------------
        check("rst_htrans", bus_if.htrans, HASTI_TRANS_IDLE);
        check("rst_haddr", bus_if.haddr, 0);
        check("rst_hwrite", bus_if.hwrite, 0);
        check("rst_hsize", bus_if.hsize, 0);
        check("rst_hwdata", bus_if.hwdata, 0);
        check("rst_rsp_valid", bus_if.rsp_valid, 0);
        check("rst_werr_valid", bus_if.werr_valid, 0);
        check("rst_wbuf_empty", bus_if.wbuf_empty, 1);
        check("const_hprot", bus_if.hprot, 4'b0011);
        check("const_hburst", bus_if.hburst, 3'b000);
        rst_n = 1'b1;
        step();

        // ---------------- simple read ----------------
        set_req(1'b0, 32'h100, 3'd2, 32'h0);
        #1;
        check("rd_ready", bus_if.req_ready, 1);
        step();
        bus_if.req_valid = 1'b0;
        #1;
        check("rd_nonseq", bus_if.htrans, HASTI_TRANS_NONSEQ);
        check("rd_haddr", bus_if.haddr, 32'h100);
        check("rd_hwrite", bus_if.hwrite, 0);
        check("rd_hsize", bus_if.hsize, 2);
        step();
        check("rd_rsp_valid", bus_if.rsp_valid, 1);
        check("rd_rsp_rdata", bus_if.rsp_rdata, 32'hDEADBEEF);
        check("rd_rsp_err", bus_if.rsp_err, 0);
        check("rd_data_htrans", bus_if.htrans, HASTI_TRANS_IDLE);
        step();
        check("rd_rsp_pulse_end", bus_if.rsp_valid, 0);

        // ---------------- five writes, bus stalled ----------------
        abase = alog.size();
        dbase = dlog.size();
        bus_if.hready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 32'h400 + 32'(4*i), 3'd2, 32'h11110000 + 32'(i));
            #1;
            check("wr_accept", bus_if.req_ready, 1);
            step();
        end
        set_req(1'b1, 32'h410, 3'd2, 32'h11110004);
        #1;
        check("wr_full_ready", bus_if.req_ready, 0);
        check("wr_stall_haddr", bus_if.haddr, 32'h400);
        step();
        step();
        check("wr_full_ready_held", bus_if.req_ready, 0);
        check("wr_busy_not_empty", bus_if.wbuf_empty, 0);
        bus_if.hready = 1'b1;
        #1;
        wait_ready("wr5_accept");
        step();
        bus_if.req_valid = 1'b0;
        #1;
        n = 0;
        while (!bus_if.wbuf_empty && n < 100) begin
            step();
            #1;
            n++;
        end
        check("wr_drained", bus_if.wbuf_empty, 1);
        check("wr_count_at_empty", dlog.size() - dbase, 5);
        for (int i = 0; i < 5; i++) begin
            check("wr_order_addr", alog[abase+i], 32'h400 + 32'(4*i));
            check("wr_order_data", dlog[dbase+i], 32'h11110000 + 32'(i));
        end

        // ---------------- write then read, program order ----------------
        abase = alog.size();
        set_req(1'b1, 32'h200, 3'd2, 32'hCAFE0200);
        #1;
        wait_ready("wr200_accept");
        step();
        bus_if.hrdata = 32'h5A5A5A5A;
        set_req(1'b0, 32'h200, 3'd2, 32'h0);
        #1;
        check("rd_blocked", bus_if.req_ready, 0);
        wait_ready("rd200_accept");
        check("rd_accept_wbuf_empty", bus_if.wbuf_empty, 1);
        step();
        bus_if.req_valid = 1'b0;
        #1;
        n = 0;
        while (!bus_if.rsp_valid && n < 20) begin
            step();
            #1;
            n++;
        end
        check("rd200_rsp_valid", bus_if.rsp_valid, 1);
        check("rd200_rdata", bus_if.rsp_rdata, 32'h5A5A5A5A);
        check("ord0_addr", alog[abase], 32'h200);
        check("ord0_write", wlog[abase], 1);
        check("ord1_addr", alog[abase+1], 32'h200);
        check("ord1_write", wlog[abase+1], 0);
        step();

        // ---------------- posted-write errors ----------------
        bus_write(32'h300, 32'h0, 1'b1, 1'b0);
        #1;
        check("werr1_valid", bus_if.werr_valid, 1);
        check("werr1_addr", bus_if.werr_addr, 32'h300);
        bus_write(32'h304, 32'h0, 1'b1, 1'b0);
        #1;
        check("werr2_sticky_addr", bus_if.werr_addr, 32'h300);
        bus_write(32'h308, 32'h0, 1'b1, 1'b1);
        #1;
        check("werr3_clr_valid", bus_if.werr_valid, 1);
        check("werr3_clr_addr", bus_if.werr_addr, 32'h308);
        bus_if.werr_clr = 1'b1;
        step();
        bus_if.werr_clr = 1'b0;
        #1;
        check("werr_cleared", bus_if.werr_valid, 0);

        // ---------------- illegal requests ----------------
        abase = alog.size();
        set_req(1'b0, 32'h102, 3'd2, 32'h0);
        #1;
        check("mis_rd_ready", bus_if.req_ready, 1);
        step();
        bus_if.req_valid = 1'b0;
        #1;
        check("mis_rd_rsp_valid", bus_if.rsp_valid, 1);
        check("mis_rd_rsp_err", bus_if.rsp_err, 1);
        check("mis_rd_no_nonseq", bus_if.htrans, HASTI_TRANS_IDLE);
        step();
        check("mis_rd_pulse_end", bus_if.rsp_valid, 0);
        check("mis_rd_no_bus", alog.size() - abase, 0);
        set_req(1'b1, 32'h500, 3'd3, 32'h0);
        #1;
        check("big_wr_ready", bus_if.req_ready, 1);
        step();
        bus_if.req_valid = 1'b0;
        #1;
        check("big_wr_werr", bus_if.werr_valid, 1);
        check("big_wr_werr_addr", bus_if.werr_addr, 32'h500);
        check("big_wr_dropped", bus_if.wbuf_empty, 1);
        bus_if.werr_clr = 1'b1;
        step();
        bus_if.werr_clr = 1'b0;

        // ---------------- reset during a stalled address phase ----------------
        bus_if.hready = 1'b0;
        set_req(1'b1, 32'h600, 3'd2, 32'h66666666);
        #1;
        wait_ready("rst_wr0_accept");
        step();
        set_req(1'b1, 32'h604, 3'd2, 32'h66666667);
        #1;
        wait_ready("rst_wr1_accept");
        step();
        bus_if.req_valid = 1'b0;
        #1;
        n = 0;
        while (bus_if.htrans != HASTI_TRANS_NONSEQ && n < 20) begin
            step();
            #1;
            n++;
        end
        check("rst_pre_nonseq", bus_if.htrans, HASTI_TRANS_NONSEQ);
        rst_n = 1'b0;
        #1;
        check("rst_mid_htrans", bus_if.htrans, HASTI_TRANS_IDLE);
        check("rst_mid_haddr", bus_if.haddr, 0);
        check("rst_mid_hwrite", bus_if.hwrite, 0);
        check("rst_mid_hwdata", bus_if.hwdata, 0);
        check("rst_mid_wbuf_empty", bus_if.wbuf_empty, 1);
        check("rst_mid_werr", bus_if.werr_valid, 0);
        step();
        rst_n = 1'b1;
        bus_if.hready = 1'b1;
        abase = alog.size();
        repeat (6) step();
        check("rst_no_replay", alog.size() - abase, 0);
        check("rst_post_empty", bus_if.wbuf_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
